// File: rtl/alu_ctrl_pkg.sv
// Shared types and op-code constants for the ALU arbiter slice.
// Imported by the Alu datapath and the arbiter top.
package alu_ctrl_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] SEL_AND = 4'b0000;
   localparam logic [3:0] SEL_OR  = 4'b0001;
   localparam logic [3:0] SEL_ADD = 4'b0010;

   function automatic logic sel_supported(input logic [3:0] sel);
      return (sel == SEL_AND) || (sel == SEL_OR) || (sel == SEL_ADD);
   endfunction

endpackage

// File: rtl/Alu.sv
// Combinational AND/OR/ADD datapath with carry-out and zero flag.
// Unsupported op codes produce an all-zero result.
module Alu #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [3:0]        ALU_Sel,
   output logic [DATA_W-1:0] ALU_Out,
   output logic              coutfin,
   output logic              z
);
   import alu_ctrl_pkg::*;

   logic [DATA_W:0] sum;

   assign sum = {1'b0, A} + {1'b0, B};

   always_comb begin
      ALU_Out = '0;
      coutfin = 1'b0;
      unique case (1'b1)
         (ALU_Sel == SEL_AND): ALU_Out = A & B;
         (ALU_Sel == SEL_OR):  ALU_Out = A | B;
         (ALU_Sel == SEL_ADD): begin
            ALU_Out = sum[DATA_W-1:0];
            coutfin = sum[DATA_W];
         end
         default: ALU_Out = '0;
      endcase
   end

   assign z = ~|ALU_Out;

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for the shared Alu datapath.
// One op in flight: IDLE accepts, EXEC captures, RESP returns.
module alu_arbiter #(
   parameter int DATA_W = 32,
   parameter int N_REQ  = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [N_REQ-1:0]             req_valid,
   output logic [N_REQ-1:0]             req_ready,
   input  logic [N_REQ-1:0][DATA_W-1:0] req_a,
   input  logic [N_REQ-1:0][DATA_W-1:0] req_b,
   input  logic [N_REQ-1:0][3:0]        req_sel,
   output logic [N_REQ-1:0]             resp_valid,
   input  logic [N_REQ-1:0]             resp_ready,
   output logic [DATA_W-1:0]            resp_data,
   output logic                         resp_cout,
   output logic                         resp_z,
   output logic                         resp_err,
   output logic                         busy
);
   import alu_ctrl_pkg::*;

   state_t state_q, state_d;

   logic              prio_q;
   logic              owner_q;
   logic              win;
   logic              grant;
   logic              capture;
   logic              done;

   logic [DATA_W-1:0] op_a_q;
   logic [DATA_W-1:0] op_b_q;
   logic [3:0]        op_sel_q;

   logic [DATA_W-1:0] res_data_q;
   logic              res_cout_q;
   logic              res_z_q;
   logic              res_err_q;

   logic [DATA_W-1:0] alu_out;
   logic              alu_cout;
   logic              alu_z;

   Alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .A       (op_a_q),
      .B       (op_b_q),
      .ALU_Sel (op_sel_q),
      .ALU_Out (alu_out),
      .coutfin (alu_cout),
      .z       (alu_z)
   );

   // Contention goes to prio; a lone requester wins regardless of prio.
   assign win = (&req_valid) ? prio_q : req_valid[1];

   always_comb begin
      state_d    = state_q;
      req_ready  = '0;
      resp_valid = '0;
      grant      = 1'b0;
      capture    = 1'b0;
      done       = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Keep ready low while reset is held so outputs stay idle.
            if ((|req_valid) && rst_n) begin
               req_ready[win] = 1'b1;
               grant          = 1'b1;
               state_d        = EXEC;
            end
         end
         EXEC: begin
            capture = 1'b1;
            state_d = RESP;
         end
         RESP: begin
            resp_valid[owner_q] = 1'b1;
            if (resp_ready[owner_q]) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q     <= 1'b0;
         owner_q    <= 1'b0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         op_sel_q   <= '0;
         res_data_q <= '0;
         res_cout_q <= 1'b0;
         res_z_q    <= 1'b0;
         res_err_q  <= 1'b0;
      end else begin
         if (grant) begin
            owner_q  <= win;
            op_a_q   <= req_a[win];
            op_b_q   <= req_b[win];
            op_sel_q <= req_sel[win];
         end
         if (capture) begin
            res_data_q <= alu_out;
            res_cout_q <= alu_cout;
            res_z_q    <= alu_z;
            res_err_q  <= !sel_supported(op_sel_q);
         end
         if (done) begin
            prio_q <= ~owner_q;
         end
      end
   end

   assign resp_data = res_data_q;
   assign resp_cout = res_cout_q;
   assign resp_z    = res_z_q;
   assign resp_err  = res_err_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter.
// Reference model: plain arithmetic plus a round-robin pointer.
module tb_alu_arbiter;
   localparam int W = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [1:0][W-1:0] req_a;
   logic [1:0][W-1:0] req_b;
   logic [1:0][3:0]   req_sel;
   logic [1:0]        resp_valid;
   logic [1:0]        resp_ready;
   logic [W-1:0]      resp_data;
   logic              resp_cout;
   logic              resp_z;
   logic              resp_err;
   logic              busy;

   int n_checks = 0;
   int n_errors = 0;
   int m_prio   = 0;

   always #5 clk = ~clk;

   alu_arbiter #(
      .DATA_W (W),
      .N_REQ  (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_sel    (req_sel),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_cout  (resp_cout),
      .resp_z     (resp_z),
      .resp_err   (resp_err),
      .busy       (busy)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected {err, z, cout, data} straight from the op-code rules.
   function automatic logic [W+2:0] ref_op(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [3:0] sel);
      longint unsigned s;
      logic [W-1:0]    d;
      logic            c;
      logic            e;
      d = '0;
      c = 1'b0;
      e = 1'b0;
      if (sel == 4'd0) d = a & b;
      else if (sel == 4'd1) d = a | b;
      else if (sel == 4'd2) begin
         s = longint'(a) + longint'(b);
         d = W'(s % (64'd1 << W));
         c = (s >= (64'd1 << W));
      end else e = 1'b1;
      return {e, (d == '0), c, d};
   endfunction

   task automatic op(input logic [1:0] vld, input int stall, output int own);
      logic [W+2:0] e;
      logic [W-1:0] held;
      int           exp_own;
      int           waited;
      exp_own = (vld == 2'b11) ? m_prio : (vld[1] ? 1 : 0);
      req_valid  = vld;
      resp_ready = 2'b00;
      #1;
      waited = 0;
      while (req_ready == 2'b00 && waited < 4) begin
         @(negedge clk);
         waited++;
      end
      chk("grant", req_ready, 64'(2'b01 << exp_own));
      own = -1;
      if (req_ready == 2'b00) return;
      own = req_ready[1] ? 1 : 0;
      e = ref_op(req_a[exp_own], req_b[exp_own], req_sel[exp_own]);
      @(negedge clk);
      chk("exec", {busy, resp_valid, req_ready}, 64'b10000);
      @(negedge clk);
      chk("resp_valid", resp_valid, 64'(2'b01 << exp_own));
      chk("resp_data", resp_data, e[W-1:0]);
      chk("resp_flags", {resp_err, resp_z, resp_cout}, e[W+2:W]);
      held = resp_data;
      for (int i = 0; i < stall; i++) begin
         resp_ready = 2'b01 << (1 - exp_own);
         @(negedge clk);
         chk("stall", {busy, resp_valid, req_ready, resp_data},
             {1'b1, 2'(2'b01 << exp_own), 2'b00, held});
      end
      resp_ready = 2'b01 << exp_own;
      @(posedge clk);
      m_prio = 1 - exp_own;
      #1;
      chk("released", {busy, resp_valid}, 64'b000);
      @(negedge clk);
      resp_ready = 2'b00;
   endtask

   task automatic set_op(input int r, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [3:0] sel);
      req_a[r]   = a;
      req_b[r]   = b;
      req_sel[r] = sel;
   endtask

   initial begin
      int          own;
      logic [3:0]  s;
      rst_n      = 1'b0;
      req_valid  = 2'b00;
      resp_ready = 2'b00;
      req_a      = '0;
      req_b      = '0;
      req_sel    = '0;
      repeat (2) @(negedge clk);
      chk("reset_outs",
          {req_ready, resp_valid, resp_data, resp_cout, resp_z, resp_err, busy},
          64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_no_req", {req_ready, busy}, 64'd0);

      set_op(0, 32'd1, 32'd2, 4'b0000);
      op(2'b01, 0, own);
      set_op(0, 32'd1, 32'd2, 4'b0001);
      op(2'b01, 0, own);
      set_op(0, 32'd3, 32'd4, 4'b0010);
      op(2'b01, 0, own);
      set_op(0, 32'hFFFF_FFFF, 32'd1, 4'b0010);
      op(2'b01, 0, own);
      set_op(0, 32'd5, 32'd6, 4'b1111);
      op(2'b01, 0, own);

      // Contention straight after reset: order 0,1,0,1.
      rst_n = 1'b0;
      #1;
      rst_n  = 1'b1;
      m_prio = 0;
      set_op(0, 32'h10, 32'h01, 4'b0010);
      set_op(1, 32'hF0, 32'h0F, 4'b0001);
      for (int i = 0; i < 4; i++) begin
         op(2'b11, 0, own);
         chk("rr_order", 64'(own), 64'(i % 2));
      end

      // Stall with the non-owner's ready asserted.
      set_op(1, 32'hA5A5_0000, 32'h0000_5A5A, 4'b0010);
      op(2'b10, 5, own);

      // Reset during EXEC.
      set_op(0, 32'd9, 32'd9, 4'b0010);
      req_valid = 2'b01;
      @(negedge clk);
      chk("rst_exec_busy", busy, 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async",
          {req_ready, resp_valid, resp_data, resp_cout, resp_z, resp_err, busy},
          64'd0);
      m_prio = 0;
      req_valid = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_no_resp", {resp_valid, busy}, 64'd0);
      end
      op(2'b01, 0, own);

      // Random traffic.
      for (int i = 0; i < 30; i++) begin
         for (int r = 0; r < 2; r++) begin
            case ($urandom_range(0, 4))
               0: s = 4'b0000;
               1: s = 4'b0001;
               2: s = 4'b0010;
               default: s = 4'($urandom_range(3, 15));
            endcase
            if ($urandom_range(0, 3) == 0)
               set_op(r, 32'hFFFF_FFFF - $urandom_range(0, 3), $urandom, s);
            else
               set_op(r, $urandom, $urandom, s);
         end
         op(2'($urandom_range(1, 3)), $urandom_range(0, 3), own);
      end

      req_valid = 2'b00;
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
